// File: rtl/nn_layer_pkg.sv
// Shared definitions for the neural-network layer blocks.
//   loader_state_t      : states of the neuron weight loader FSM
//   WORDS_PER_NEURON    : words stored per neuron (weights + bias) for the
//                         default layer; neuron RAM depth uses the same value
//   words_per_neuron()  : same helper for parameterised instances
package nn_layer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        STREAM,
        WAIT_LOADED,
        START,
        DONE,
        ERROR
    } loader_state_t;

    localparam int DEFAULT_PREVLAYER_COUNT = 169;
    localparam int WORDS_PER_NEURON        = DEFAULT_PREVLAYER_COUNT + 1;

    // Each neuron receives one weight per previous-layer neuron plus its bias.
    function automatic int words_per_neuron(input int prevlayer_count);
        return prevlayer_count + 1;
    endfunction

endpackage

// File: rtl/neuron_weight_loader_if.sv
// Weight-load bus between a layer's loader, its weight ROM and its neurons.
//   rom_addr/rom_rd_en  : loader -> ROM read request
//   rom_rdata           : ROM -> loader, valid exactly one cycle after rom_rd_en
//   load_weights        : loader -> neurons, level, neurons in weight-load mode
//   weight_val/valid    : loader -> neurons, broadcast word
//   part_number         : loader -> neurons, index of the neuron owning the word
//   weights_loaded      : neurons -> loader, one load-complete flag per neuron
//   start               : loader -> neurons, one-cycle start pulse
// Modports: master = loader, slave = ROM/neuron side.
//
// Handshake: weight_valid is a broadcast qualifier with no ready. Every cycle
// with weight_valid=1 carries exactly one word that all neurons must accept;
// part_number selects which neuron stores it. When weight_valid=0,
// weight_val and part_number are both 0.
interface neuron_weight_loader_if #(
    parameter int WEIGHT_WIDTH      = 16,
    parameter int NEURON_COUNT      = 30,
    parameter int PART_NUMBER_WIDTH = 6,
    parameter int ADDR_WIDTH        = 13
);
    logic [ADDR_WIDTH-1:0]        rom_addr;
    logic                         rom_rd_en;
    logic [WEIGHT_WIDTH-1:0]      rom_rdata;
    logic                         load_weights;
    logic [WEIGHT_WIDTH-1:0]      weight_val;
    logic                         weight_valid;
    logic [PART_NUMBER_WIDTH-1:0] part_number;
    logic [NEURON_COUNT-1:0]      weights_loaded;
    logic                         start;

    modport master (
        output rom_addr, rom_rd_en, load_weights, weight_val, weight_valid,
               part_number, start,
        input  rom_rdata, weights_loaded
    );

    modport slave (
        input  rom_addr, rom_rd_en, load_weights, weight_val, weight_valid,
               part_number, start,
        output rom_rdata, weights_loaded
    );
endinterface

// File: rtl/weight_addr_gen.sv
// Address generator for the weight loader: running ROM address plus the
// part (neuron) and word-within-part counters that label each read.
//   clk, rst    : clock, async active-high reset
//   clr         : synchronous clear of all counters (start of a new load)
//   adv         : a ROM read is issued this cycle; step to the next word
//   addr        : current ROM address (part*WORDS+word, kept as a counter)
//   part, word  : labels of the word at addr
//   all_issued  : the final address has been read; no further reads
module weight_addr_gen
    import nn_layer_pkg::*;
#(
    parameter int PREVLAYER_COUNT   = 169,
    parameter int NEURON_COUNT      = 30,
    parameter int PART_NUMBER_WIDTH = 6,
    parameter int ADDR_WIDTH        = 13,
    parameter int WORD_WIDTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         adv,
    output logic [ADDR_WIDTH-1:0]        addr,
    output logic [PART_NUMBER_WIDTH-1:0] part,
    output logic [WORD_WIDTH-1:0]        word,
    output logic                         all_issued
);
    localparam int WPN = words_per_neuron(PREVLAYER_COUNT);
    localparam logic [WORD_WIDTH-1:0]        LAST_WORD = WORD_WIDTH'(WPN - 1);
    localparam logic [PART_NUMBER_WIDTH-1:0] LAST_PART = PART_NUMBER_WIDTH'(NEURON_COUNT - 1);

    logic last;
    assign last = (part == LAST_PART) && (word == LAST_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr       <= '0;
            part       <= '0;
            word       <= '0;
            all_issued <= 1'b0;
        end else if (clr) begin
            addr       <= '0;
            part       <= '0;
            word       <= '0;
            all_issued <= 1'b0;
        end else if (adv) begin
            if (last) begin
                // Hold on the final address; the FSM drops the read strobe.
                all_issued <= 1'b1;
            end else begin
                addr <= addr + ADDR_WIDTH'(1);
                if (word == LAST_WORD) begin
                    word <= '0;
                    part <= part + PART_NUMBER_WIDTH'(1);
                end else begin
                    word <= word + WORD_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: rtl/neuron_weight_loader.sv
// Transmit side of a layer's neuron weight-load interface. Streams
// PREVLAYER_COUNT weights + 1 bias per neuron from a synchronous ROM to all
// neurons, tagged with part_number, waits for every weights_loaded flag and
// then pulses start together with load_weights.
//   clk, rst   : clock, async active-high reset
//   load_go    : one-cycle request to load the whole layer (ignored while busy)
//   bus        : weight-load bus, master side (ROM port + neuron broadcast)
//   busy       : load in progress (ARM, STREAM, WAIT_LOADED, START)
//   done       : level, load finished and start issued
//   error      : level, neurons did not all report loaded within TIMEOUT_CYCLES
//   state_dbg  : current FSM state
//   checksum   : (only with WEIGHT_CHECKSUM_EN) wrapping sum of sign-extended
//                words broadcast in the current load
// Optional feature macro: WEIGHT_CHECKSUM_EN.
module neuron_weight_loader
    import nn_layer_pkg::*;
#(
    parameter int WEIGHT_WIDTH      = 16,
    parameter int PREVLAYER_COUNT   = 169,
    parameter int NEURON_COUNT      = 30,
    parameter int PART_NUMBER_WIDTH = 6,
    parameter int ADDR_WIDTH        = 13,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_go,
    neuron_weight_loader_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output loader_state_t          state_dbg
`ifdef WEIGHT_CHECKSUM_EN
    ,
    output logic [31:0]            checksum
`endif
);
    localparam int WPN         = words_per_neuron(PREVLAYER_COUNT);
    localparam int WORD_WIDTH  = $clog2(WPN + 1);
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WORD_WIDTH-1:0]        LAST_WORD = WORD_WIDTH'(WPN - 1);
    localparam logic [PART_NUMBER_WIDTH-1:0] LAST_PART = PART_NUMBER_WIDTH'(NEURON_COUNT - 1);

    loader_state_t                state_q, state_d;
    logic                         go_accept;
    logic                         rd_en;
    logic                         all_issued;
    logic [PART_NUMBER_WIDTH-1:0] part;
    logic [WORD_WIDTH-1:0]        word;
    logic                         rd_q;
    logic [PART_NUMBER_WIDTH-1:0] part_q;
    logic [WORD_WIDTH-1:0]        word_q;
    logic [TIMER_WIDTH-1:0]       timer_q;
    logic                         stream_last;
    logic                         timed_out;

    assign go_accept   = load_go && (state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign stream_last = rd_q && (part_q == LAST_PART) && (word_q == LAST_WORD);
    assign timed_out   = (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
    assign state_dbg   = state_q;

    weight_addr_gen #(
        .PREVLAYER_COUNT  (PREVLAYER_COUNT),
        .NEURON_COUNT     (NEURON_COUNT),
        .PART_NUMBER_WIDTH(PART_NUMBER_WIDTH),
        .ADDR_WIDTH       (ADDR_WIDTH),
        .WORD_WIDTH       (WORD_WIDTH)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (go_accept),
        .adv       (rd_en),
        .addr      (bus.rom_addr),
        .part      (part),
        .word      (word),
        .all_issued(all_issued)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        rd_en            = 1'b0;
        bus.load_weights = 1'b0;
        bus.start        = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        error            = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_accept) state_d = ARM;
            end
            ARM: begin
                // First ROM read goes out here so word 0 lands in the first
                // STREAM cycle, while neurons already see load_weights.
                bus.load_weights = 1'b1;
                busy             = 1'b1;
                rd_en            = 1'b1;
                state_d          = STREAM;
            end
            STREAM: begin
                bus.load_weights = 1'b1;
                busy             = 1'b1;
                rd_en            = !all_issued;
                if (stream_last) state_d = WAIT_LOADED;
            end
            WAIT_LOADED: begin
                bus.load_weights = 1'b1;
                busy             = 1'b1;
                if (&bus.weights_loaded) state_d = START;
                else if (timed_out)      state_d = ERROR;
            end
            START: begin
                // Neurons latch start only while load_weights is still high.
                bus.load_weights = 1'b1;
                bus.start        = 1'b1;
                busy             = 1'b1;
                state_d          = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (go_accept) state_d = ARM;
            end
            ERROR: begin
                error = 1'b1;
                if (go_accept) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase
    end

    // Alignment stage: labels follow the read by one cycle to meet the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= 1'b0;
            part_q <= '0;
            word_q <= '0;
        end else begin
            rd_q   <= rd_en;
            part_q <= part;
            word_q <= word;
        end
    end

    assign bus.rom_rd_en    = rd_en;
    assign bus.weight_valid = rd_q;
    assign bus.weight_val   = rd_q ? bus.rom_rdata : WEIGHT_WIDTH'(0);
    assign bus.part_number  = rd_q ? part_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       timer_q <= '0;
        else if (state_q == WAIT_LOADED) timer_q <= timer_q + TIMER_WIDTH'(1);
        else                           timer_q <= '0;
    end

`ifdef WEIGHT_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 checksum <= '0;
        else if (state_q == ARM) checksum <= '0;
        else if (rd_q)           checksum <= checksum + 32'($signed(bus.weight_val));
    end
`endif

endmodule
